// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction-fetch path (IF) and the
//   load/store path (LS). One requester is granted at a time. The memory
//   transaction runs through IDLE -> BUSY_IF/BUSY_LS -> IDLE, and read data
//   is returned with a one-cycle rvalid pulse. stall_o holds the pipeline
//   while the port is busy or a request is still waiting for its grant.
//
//   LS normally has priority. IF takes the port after it has lost STARVE_MAX
//   consecutive arbitrations while requesting.
//
//   Optional build macro MEM_ARB_TIMEOUT_EN adds err_o and a BUSY watchdog.
//   The watchdog aborts a transaction after TIMEOUT_CYCLES cycles without
//   mem_ack_i.
//
// Ports
//   clk_i, rst_i         clock and synchronous active-low reset
//   if_*                 fetch request/grant/completion
//   ls_*                 load/store request/grant/completion
//   mem_*                registered memory request, ack and read data
//   stall_o              port busy or a request is pending ungranted
//   err_o                (MEM_ARB_TIMEOUT_EN only) timeout abort pulse
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_o
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                err_o
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam int STW  = $clog2(STARVE_MAX + 1);
  localparam logic [STW-1:0] STARVE_LIM = STW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t              state_q,     state_d;
  logic [STW-1:0]      starve_q,    starve_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q,    mem_be_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0]   ls_rdata_q,  ls_rdata_d;

  logic                busy;
  logic                tmo_hit;
  logic                finish;
  logic                ls_win;
  logic [DATA_W-1:0]   ret_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]       tmo_cnt_q,   tmo_cnt_d;
  logic                err_q,       err_d;

  // Counter value k means this is the (k+1)-th BUSY cycle; an ack in the
  // same cycle wins over the abort.
  assign tmo_hit = busy & ~mem_ack_i & (tmo_cnt_q == TMO_LAST);
  assign err_o   = err_q;
`else
  assign tmo_hit = 1'b0;
`endif

  assign busy   = (state_q != IDLE);
  assign finish = busy & (mem_ack_i | tmo_hit);

  // LS has priority unless IF has been starved long enough.
  assign ls_win   = ls_req_i & ~((starve_q == STARVE_LIM) & if_req_i);
  // Grants are suppressed while reset is held so nothing looks accepted.
  assign ls_gnt_o = rst_i & ~busy & ls_win;
  assign if_gnt_o = rst_i & ~busy & ~ls_win & if_req_i;

  // Stores and timeout aborts return zero data.
  assign ret_data = (mem_ack_i && !(state_q == BUSY_LS && mem_we_q)) ? mem_rdata_i : '0;

  assign stall_o = busy | (if_req_i & ~if_gnt_o) | (ls_req_i & ~ls_gnt_o);

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = 1'b0;
`endif
    if (ls_gnt_o) begin
      state_d     = BUSY_LS;
      mem_req_d   = 1'b1;
      mem_we_d    = ls_we_i;
      mem_addr_d  = ls_addr_i;
      mem_wdata_d = ls_wdata_i;
      mem_be_d    = ls_be_i;
      if (if_req_i && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_d   = '0;
`endif
    end else if (if_gnt_o) begin
      state_d     = BUSY_IF;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr_i;
      mem_wdata_d = '0;
      mem_be_d    = '1;
      starve_d    = '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_d   = '0;
`endif
    end else if (finish) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      if (state_q == BUSY_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = ret_data;
      end else begin
        ls_rvalid_d = 1'b1;
        ls_rdata_d  = ret_data;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      err_d = tmo_hit;
`endif
    end else if (busy) begin
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 ns after the
// rising edge; outputs are sampled 2 ns after the rising edge.
module tb_mem_port_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic [3:0]  ls_be_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        err_o;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o)
`ifdef MEM_ARB_TIMEOUT_EN
    , .err_o(err_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0; if_req_i = 0; ls_req_i = 0; mem_ack_i = 0;
    if_addr_i = '0; ls_we_i = 0; ls_addr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
    mem_rdata_i = '0;
    tick; tick; #1;
    total_cnt++;
    if ({mem_req_o, mem_we_o, if_rvalid_o, ls_rvalid_o} !== 4'b0)
      $display("FAIL reset_ctrl: got %b exp 0000", {mem_req_o, mem_we_o, if_rvalid_o, ls_rvalid_o});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr_o, mem_wdata_o, mem_be_o} !== 68'h0)
      $display("FAIL reset_mem_bus: got %h exp 0", {mem_addr_o, mem_wdata_o, mem_be_o});
    else pass_cnt++;
    total_cnt++;
    if ({if_rdata_o, ls_rdata_o} !== 64'h0)
      $display("FAIL reset_rdata: got %h exp 0", {if_rdata_o, ls_rdata_o});
    else pass_cnt++;
    rst_i = 1'b1;
    tick; #1;
    total_cnt++;
    if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b exp 0", stall_o);
    else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_single_fetch;
    tick;
    if_req_i = 1; if_addr_i = 32'h10; #1;
    total_cnt++;
    if ({if_gnt_o, ls_gnt_o, stall_o} !== 3'b100)
      $display("FAIL fetch_gnt: got %b exp 100", {if_gnt_o, ls_gnt_o, stall_o});
    else pass_cnt++;
    tick; if_req_i = 0; if_addr_i = '0; #1;
    total_cnt++;
    if ({mem_req_o, mem_we_o, mem_be_o, if_gnt_o, stall_o} !== 8'b10_1111_01)
      $display("FAIL fetch_mem_ctrl: got %b exp 10111101", {mem_req_o, mem_we_o, mem_be_o, if_gnt_o, stall_o});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr_o !== 32'h10) $display("FAIL fetch_addr: got %h exp 00000010", mem_addr_o);
    else pass_cnt++;
    tick; #1;
    total_cnt++;
    if (mem_req_o !== 1'b1) $display("FAIL fetch_req_hold: got %b exp 1", mem_req_o);
    else pass_cnt++;
    tick; mem_ack_i = 1; mem_rdata_i = 32'h0050_0093; #1;
    total_cnt++;
    if (if_rvalid_o !== 1'b0) $display("FAIL fetch_early_rvalid: got %b exp 0", if_rvalid_o);
    else pass_cnt++;
    tick; mem_ack_i = 0; mem_rdata_i = '0; #1;
    total_cnt++;
    if ({if_rvalid_o, mem_req_o, stall_o} !== 3'b100)
      $display("FAIL fetch_done_ctrl: got %b exp 100", {if_rvalid_o, mem_req_o, stall_o});
    else pass_cnt++;
    total_cnt++;
    if (if_rdata_o !== 32'h0050_0093) $display("FAIL fetch_rdata: got %h exp 00500093", if_rdata_o);
    else pass_cnt++;
    tick; #1;
    total_cnt++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b0, 32'h0050_0093})
      $display("FAIL fetch_rdata_hold: got %b/%h exp 0/00500093", if_rvalid_o, if_rdata_o);
    else pass_cnt++;
    $display("single_fetch: addr=00000010 rdata=%h", if_rdata_o);
  endtask

  task automatic test_simultaneous;
    tick;
    if_req_i = 1; if_addr_i = 32'h20;
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h100; ls_wdata_i = 32'hDEAD_BEEF; ls_be_i = 4'b0011;
    #1;
    total_cnt++;
    if ({ls_gnt_o, if_gnt_o, stall_o} !== 3'b101)
      $display("FAIL simul_gnt: got %b exp 101", {ls_gnt_o, if_gnt_o, stall_o});
    else pass_cnt++;
    tick;
    ls_req_i = 0; ls_we_i = 0; ls_addr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
    mem_ack_i = 1; mem_rdata_i = 32'h1234_5678; #1;
    total_cnt++;
    if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF})
      $display("FAIL simul_store_bus: got we=%b be=%b addr=%h wdata=%h exp 1/0011/00000100/deadbeef",
               mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    else pass_cnt++;
    total_cnt++;
    if ({if_gnt_o, stall_o} !== 2'b01) $display("FAIL simul_if_wait: got %b exp 01", {if_gnt_o, stall_o});
    else pass_cnt++;
    tick; mem_ack_i = 0; #1;
    total_cnt++;
    if ({ls_rvalid_o, if_gnt_o, mem_req_o} !== 3'b110)
      $display("FAIL simul_handover: got %b exp 110", {ls_rvalid_o, if_gnt_o, mem_req_o});
    else pass_cnt++;
    total_cnt++;
    if (ls_rdata_o !== 32'h0) $display("FAIL simul_store_rdata: got %h exp 00000000", ls_rdata_o);
    else pass_cnt++;
    tick; if_req_i = 0; if_addr_i = '0; mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D; #1;
    total_cnt++;
    if ({mem_addr_o, mem_we_o, mem_be_o, ls_rvalid_o} !== {32'h20, 1'b0, 4'hF, 1'b0})
      $display("FAIL simul_if_bus: got addr=%h we=%b be=%b lsrv=%b exp 00000020/0/1111/0",
               mem_addr_o, mem_we_o, mem_be_o, ls_rvalid_o);
    else pass_cnt++;
    tick; mem_ack_i = 0; mem_rdata_i = '0; #1;
    total_cnt++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'hCAFE_F00D})
      $display("FAIL simul_if_done: got %b/%h exp 1/cafef00d", if_rvalid_o, if_rdata_o);
    else pass_cnt++;
    $display("simultaneous: ls store then if fetch rdata=%h", if_rdata_o);
  endtask

  task automatic test_starvation;
    // Grant order with both requests held: 4x LS, IF, 4x LS, IF, LS.
    logic [10:0] exp_if;
    int g;
    exp_if = 11'b010_0001_0000;
    g = 0;
    tick;
    ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h300; ls_be_i = 4'hF;
    if_req_i = 1; if_addr_i = 32'h40; mem_rdata_i = 32'hA5A5_A5A5;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) tick;
      mem_ack_i = (c % 2 == 1);
      #1;
      total_cnt++;
      if (c % 2 == 0) begin
        if ({if_gnt_o, ls_gnt_o} !== {exp_if[g], ~exp_if[g]})
          $display("FAIL starve_grant%0d: got if=%b ls=%b exp if=%b ls=%b",
                   g, if_gnt_o, ls_gnt_o, exp_if[g], ~exp_if[g]);
        else pass_cnt++;
        $display("starvation: grant %0d if=%b ls=%b", g, if_gnt_o, ls_gnt_o);
        g++;
      end else begin
        if ({if_gnt_o, ls_gnt_o} !== 2'b00)
          $display("FAIL starve_busy_gnt%0d: got %b exp 00", c, {if_gnt_o, ls_gnt_o});
        else pass_cnt++;
      end
    end
    tick; if_req_i = 0; ls_req_i = 0; mem_ack_i = 0; #1;
    total_cnt++;
    if ({ls_rvalid_o, ls_rdata_o, stall_o} !== {1'b1, 32'hA5A5_A5A5, 1'b0})
      $display("FAIL starve_last: got %b/%h/%b exp 1/a5a5a5a5/0", ls_rvalid_o, ls_rdata_o, stall_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_txn;
    tick; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h200; #1;
    total_cnt++;
    if (ls_gnt_o !== 1'b1) $display("FAIL rstmid_gnt: got %b exp 1", ls_gnt_o);
    else pass_cnt++;
    tick; ls_req_i = 0; rst_i = 0; #1;
    total_cnt++;
    if (mem_req_o !== 1'b1) $display("FAIL rstmid_busy: got %b exp 1", mem_req_o);
    else pass_cnt++;
    tick; rst_i = 1; mem_ack_i = 1; mem_rdata_i = 32'hBAD0_BAD0; #1;
    total_cnt++;
    if ({mem_req_o, stall_o, ls_rvalid_o} !== 3'b000)
      $display("FAIL rstmid_after: got %b exp 000", {mem_req_o, stall_o, ls_rvalid_o});
    else pass_cnt++;
    tick; mem_ack_i = 0; mem_rdata_i = '0; #1;
    total_cnt++;
    if ({ls_rvalid_o, ls_rdata_o, mem_req_o} !== 34'h0)
      $display("FAIL rstmid_ack_ignored: got %b/%h/%b exp 0/00000000/0", ls_rvalid_o, ls_rdata_o, mem_req_o);
    else pass_cnt++;
    if_req_i = 1; if_addr_i = 32'h44; #1;
    total_cnt++;
    if (if_gnt_o !== 1'b1) $display("FAIL rstmid_idle_gnt: got %b exp 1", if_gnt_o);
    else pass_cnt++;
    tick; if_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h77; #1;
    total_cnt++;
    if (mem_addr_o !== 32'h44) $display("FAIL rstmid_new_addr: got %h exp 00000044", mem_addr_o);
    else pass_cnt++;
    tick; mem_ack_i = 0; mem_rdata_i = '0; #1;
    total_cnt++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h77})
      $display("FAIL rstmid_new_done: got %b/%h exp 1/00000077", if_rvalid_o, if_rdata_o);
    else pass_cnt++;
    $display("reset_mid_txn: in-flight load dropped");
  endtask

  task automatic test_stall;
    tick; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h400; #1;
    total_cnt++;
    if ({ls_gnt_o, stall_o} !== 2'b10) $display("FAIL stall_ls_gnt: got %b exp 10", {ls_gnt_o, stall_o});
    else pass_cnt++;
    tick; ls_req_i = 0; if_req_i = 1; if_addr_i = 32'h48; #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick;
      mem_ack_i = (k == 2);
      mem_rdata_i = (k == 2) ? 32'h1111_2222 : 32'h0;
      #1;
      total_cnt++;
      if ({stall_o, if_gnt_o} !== 2'b10)
        $display("FAIL stall_busy%0d: got %b exp 10", k, {stall_o, if_gnt_o});
      else pass_cnt++;
    end
    tick; mem_ack_i = 0; mem_rdata_i = '0; #1;
    total_cnt++;
    if ({if_gnt_o, stall_o, ls_rvalid_o} !== 3'b101)
      $display("FAIL stall_if_gnt: got %b exp 101", {if_gnt_o, stall_o, ls_rvalid_o});
    else pass_cnt++;
    total_cnt++;
    if (ls_rdata_o !== 32'h1111_2222) $display("FAIL stall_ls_rdata: got %h exp 11112222", ls_rdata_o);
    else pass_cnt++;
    tick; if_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h99; #1;
    total_cnt++;
    if ({stall_o, mem_addr_o} !== {1'b1, 32'h48})
      $display("FAIL stall_busy_if: got %b/%h exp 1/00000048", stall_o, mem_addr_o);
    else pass_cnt++;
    tick; mem_ack_i = 0; mem_rdata_i = '0; #1;
    total_cnt++;
    if ({stall_o, if_rvalid_o} !== 2'b01) $display("FAIL stall_idle: got %b exp 01", {stall_o, if_rvalid_o});
    else pass_cnt++;
    $display("stall: held until if grant");
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    tick; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h500; #1;
    total_cnt++;
    if (ls_gnt_o !== 1'b1) $display("FAIL tmo_gnt: got %b exp 1", ls_gnt_o);
    else pass_cnt++;
    tick; ls_req_i = 0; #1;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin tick; #1; end
      total_cnt++;
      if ({mem_req_o, ls_rvalid_o, err_o} !== 3'b100)
        $display("FAIL tmo_wait%0d: got %b exp 100", k, {mem_req_o, ls_rvalid_o, err_o});
      else pass_cnt++;
    end
    tick; #1;
    total_cnt++;
    if ({ls_rvalid_o, err_o, mem_req_o, ls_rdata_o} !== {3'b110, 32'h0})
      $display("FAIL tmo_abort: got %b%b%b/%h exp 110/00000000", ls_rvalid_o, err_o, mem_req_o, ls_rdata_o);
    else pass_cnt++;
    tick; #1;
    total_cnt++;
    if ({ls_rvalid_o, err_o} !== 2'b00) $display("FAIL tmo_pulse: got %b exp 00", {ls_rvalid_o, err_o});
    else pass_cnt++;
    $display("timeout: load aborted after 8 busy cycles");
  endtask
`endif

  initial begin
    test_reset;
    test_single_fetch;
    test_simultaneous;
    test_starvation;
    test_reset_mid_txn;
    test_stall;
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
